// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache lookup and line refill controller
module icache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req_valid_i,
    output logic                   cpu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
    output logic                   cpu_rsp_valid_o,
    output logic [31:0]            cpu_rdata_o,
    input  logic                   invalidate_i,
    output logic [INDEX_WIDTH-1:0] tag_index_o,
    output logic                   tag_wr_en_o,
    output logic [TAG_WIDTH-1:0]   tag_wr_tag_o,
    input  logic [TAG_WIDTH-1:0]   tag_rd_tag_i,
    output logic [INDEX_WIDTH+1:0] data_addr_o,
    output logic                   data_wr_en_o,
    output logic [31:0]            data_wr_data_o,
    input  logic [31:0]            data_rd_data_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [31:0]            mem_rsp_data_i
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_REFILL   = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]                    state, state_nxt;
    logic                          started;
    logic [TAG_WIDTH-1:0]          tag_q;
    logic [INDEX_WIDTH-1:0]        idx_q;
    logic [1:0]                    word_q;
    logic [1:0]                    beat_q;
    logic                          stale_q;
    logic [31:0]                   rsp_q;
    logic [(1<<INDEX_WIDTH)-1:0]   valid_q;
    logic                          ready, accept, hit, refill_beat, beat_last;
    logic                          unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // ready is held low through the first edge after reset release
    assign ready       = (state == S_IDLE) & started;
    assign accept      = cpu_req_valid_i & ready;
    assign hit         = valid_q[idx_q] & (tag_rd_tag_i == tag_q);
    assign refill_beat = (state == S_REFILL) & mem_rsp_valid_i;
    assign beat_last   = refill_beat & (beat_q == 2'd3);

    assign cpu_req_ready_o = ready;

    always_comb begin
        state_nxt       = state;
        cpu_rsp_valid_o = 1'b0;
        cpu_rdata_o     = '0;
        tag_index_o     = '0;
        tag_wr_en_o     = 1'b0;
        tag_wr_tag_o    = '0;
        data_addr_o     = '0;
        data_wr_en_o    = 1'b0;
        data_wr_data_o  = '0;
        mem_req_valid_o = 1'b0;
        mem_addr_o      = '0;
        case (state)
            S_IDLE: begin
                if (ready) begin
                    tag_index_o = cpu_addr_i[INDEX_WIDTH+3:4];
                    data_addr_o = cpu_addr_i[INDEX_WIDTH+3:2];
                end
                if (accept) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_rsp_valid_o = 1'b1;
                    cpu_rdata_o     = data_rd_data_i;
                    state_nxt       = S_IDLE;
                end else begin
                    state_nxt = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = {tag_q, idx_q, 4'b0000};
                if (mem_req_ready_i) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                if (mem_rsp_valid_i) begin
                    data_wr_en_o   = 1'b1;
                    data_addr_o    = {idx_q, beat_q};
                    data_wr_data_o = mem_rsp_data_i;
                end
                if (beat_last) begin
                    tag_wr_en_o  = 1'b1;
                    tag_index_o  = idx_q;
                    tag_wr_tag_o = tag_q;
                    state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                cpu_rsp_valid_o = 1'b1;
                cpu_rdata_o     = rsp_q;
                state_nxt       = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            started <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            beat_q  <= '0;
            stale_q <= 1'b0;
            rsp_q   <= '0;
            valid_q <= '0;
        end else begin
            started <= 1'b1;
            state   <= state_nxt;
            if (accept) begin
                tag_q  <= cpu_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
                idx_q  <= cpu_addr_i[INDEX_WIDTH+3:4];
                word_q <= cpu_addr_i[3:2];
            end
            if ((state == S_MISS_REQ) && mem_req_ready_i) beat_q <= 2'd0;
            else if (refill_beat) beat_q <= beat_q + 2'd1;
            if (refill_beat && (beat_q == word_q)) rsp_q <= mem_rsp_data_i;
            // a line whose refill overlapped an invalidate must not become valid
            if (state_nxt == S_IDLE) stale_q <= 1'b0;
            else if (invalidate_i && ((state == S_MISS_REQ) || (state == S_REFILL))) stale_q <= 1'b1;
            if (invalidate_i) valid_q <= '0;
            else if (beat_last && !stale_q) valid_q[idx_q] <= 1'b1;
        end
    end

endmodule
